// File: rtl/demux_dispatch_ctrl.sv
// One-word skid demux: holds a source word and offers it to one of four sinks,
// chosen round-robin (BURST words per sink) or by address. Optional stall timeout via DEMUX_TIMEOUT_EN.
module demux_dispatch_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             mode,
  input  logic [1:0]       addr,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [1:0]       sel,
  output logic [7:0]       drop_cnt
);

  if (BURST < 1 || BURST > 255) begin : g_bad_burst
    $error("demux_dispatch_ctrl: BURST out of range 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("demux_dispatch_ctrl: TIMEOUT out of range 1..255");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             rr_q, rr_d;
  logic [3:0]       y_valid_q, y_valid_d;
  logic             deliver, drop, release_w, accept;

`ifdef DEMUX_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
`endif

  // Handshake, burst pointer and next-state logic
  always_comb begin
    deliver = |(y_valid_q & y_ready);
`ifdef DEMUX_TIMEOUT_EN
    drop = (state_q == ST_FULL) && !deliver && (stall_q == 8'(TIMEOUT - 1));
`else
    drop = 1'b0;
`endif
    // A dropped word frees the register exactly like a delivered one
    release_w = deliver | drop;
    din_ready = (state_q == ST_EMPTY) | release_w;
    accept    = din_valid & din_ready;

    state_d     = state_q;
    dout_d      = dout_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    rr_d        = rr_q;

    if (release_w && rr_q) begin
      if (burst_cnt_q == 8'(BURST - 1)) begin
        burst_cnt_d = 8'd0;
        ptr_d       = ptr_q + 2'd1;
      end else begin
        burst_cnt_d = burst_cnt_q + 8'd1;
      end
    end

    if (release_w) state_d = ST_EMPTY;

    // ptr_d already reflects a burst completed in this same cycle
    if (accept) begin
      state_d = ST_FULL;
      dout_d  = din;
      sel_d   = mode ? addr : ptr_d;
      rr_d    = ~mode;
    end

    y_valid_d = (state_d == ST_FULL) ? (4'b0001 << sel_d) : 4'b0000;

`ifdef DEMUX_TIMEOUT_EN
    stall_d    = (state_q == ST_FULL && !release_w) ? stall_q + 8'd1 : 8'd0;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      dout_q      <= '0;
      sel_q       <= 2'd0;
      ptr_q       <= 2'd0;
      burst_cnt_q <= 8'd0;
      rr_q        <= 1'b0;
      y_valid_q   <= 4'b0000;
`ifdef DEMUX_TIMEOUT_EN
      stall_q     <= 8'd0;
      drop_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rr_q        <= rr_d;
      y_valid_q   <= y_valid_d;
`ifdef DEMUX_TIMEOUT_EN
      stall_q     <= stall_d;
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign dout    = dout_q;
  assign sel     = sel_q;
  assign y_valid = y_valid_q;
`ifdef DEMUX_TIMEOUT_EN
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter BURST, default 4: words sent to one sink in round-robin mode before the pointer advances; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 16: stall cycles before a word is dropped; used only with DEMUX_TIMEOUT_EN; legal range 1..255.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1: sole clock; all state updates on its rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 din  input  WIDTH: source data word.
REQ-008 din_valid  input  1: source word present.
REQ-009 din_ready  output  1: block accepts a word this cycle.
REQ-010 mode  input  1: target select at accept; 0 = round-robin, 1 = addressed.
REQ-011 addr  input  2: target sink in addressed mode; sampled with din.
REQ-012 dout  output  WIDTH: held word, shared by all four sinks.
REQ-013 y_valid  output  4: one-hot valid; bit n qualifies dout for sink n.
REQ-014 y_ready  input  4: per-sink ready.
REQ-015 sel  output  2: index of the current target sink.
REQ-016 drop_cnt  output  8: saturating count of dropped words.

Function
REQ-017 Accept = din_valid & din_ready; deliver = |(y_valid & y_ready).
REQ-018 FSM SHALL have two states: EMPTY (no word held) and FULL (one word held in the output register).
REQ-019 din_ready SHALL be 1 in EMPTY, and 1 in FULL only in a deliver cycle (pass-through refill; no bubble).
REQ-020 On accept, din SHALL be registered into dout, the target latched into sel, and the FSM SHALL go to FULL; y_valid is asserted the next cycle (1-cycle latency).
REQ-021 Round-robin target SHALL be ptr; addressed target SHALL be addr; mode is sampled only at accept, so a mode change affects the next word only.
REQ-022 y_valid SHALL be one-hot on sel in FULL and 4'b0000 in EMPTY; dout and sel SHALL hold stable while FULL and undelivered.
REQ-023 Deliver without accept SHALL move FULL->EMPTY; deliver with accept SHALL stay FULL with the new word.
REQ-024 y_ready bits other than sel SHALL be ignored.
REQ-025 In round-robin mode, each delivered word SHALL increment burst_cnt; on reaching BURST, burst_cnt SHALL clear and ptr SHALL advance 3->0 by wrap-around.
REQ-026 Addressed-mode words SHALL leave ptr and burst_cnt unchanged.
REQ-027 The ptr used for an accept coincident with a burst-completing deliver SHALL be the advanced value.

Reset
REQ-028 While rst=1 at a clock edge: FSM=EMPTY, dout=0, sel=0, ptr=0, burst_cnt=0, stall counter=0, drop_cnt=0; y_valid=0 and din_ready=1 on the following cycle.
REQ-029 Reset mid-transfer SHALL discard any held word without delivery.

Configuration
REQ-030 Macro DEMUX_TIMEOUT_EN defined: a stall counter SHALL count FULL cycles without deliver; at TIMEOUT the word SHALL be dropped (FULL->EMPTY, or refilled if accepting), drop_cnt SHALL increment saturating at 255, and in round-robin mode the drop SHALL count as a burst word.
REQ-031 Macro DEMUX_TIMEOUT_EN undefined: words SHALL wait indefinitely, no stall counter SHALL exist, and drop_cnt SHALL be tied to 0.

Verification
REQ-032 Round-robin, BURST=4, y_ready=4'hF, 16 consecutive words 0x00..0x0F -> words 0-3 to sink 0, 4-7 to sink 1, 8-11 to sink 2, 12-15 to sink 3, one word per cycle, then ptr=0.
REQ-033 Addressed mode, addr=2, din=0xA5, y_ready=4'b0000 for 5 cycles then 4'b0100 -> y_valid=4'b0100 held with dout=0xA5, din_ready=0 until delivery, ptr unchanged.
REQ-034 Mode toggle: RR word, then addressed word to sink 3, then RR word -> sinks 0, 3, 0, with burst_cnt=2 after the sequence.
REQ-035 rst asserted while FULL with y_ready=0 -> y_valid=0 and din_ready=1 on the next cycle, no delivery, ptr=0.
REQ-036 With DEMUX_TIMEOUT_EN, TIMEOUT=16, sink 1 stalled -> word dropped after 16 FULL cycles, drop_cnt 0->1; 300 drops saturate drop_cnt at 255.
